sigfmd_seq: RTL and testbench

- Parametrised, iterative significand multiply/divide unit for the FPU multiplier path.
- Sequential, low-area successor to the combinational significand mul/div stage.
- Accepts two normalised significands, one per transaction. Computes the product (radix-2 shift-add) or quotient (restoring division) with a sticky bit.
- Valid/ready handshakes on both sides, double or single precision mode, and a synchronous flush.

---
 rtl/sigfmd_pkg.sv | 15 +
 rtl/sigfmd_step.sv | 40 ++++
 rtl/sigfmd_seq.sv | 135 +++++++++++++
 tb/tb_sigfmd_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sigfmd_pkg.sv
// Shared types and sizing helpers for the iterative significand mul/div unit.
package sigfmd_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic {OP_MUL, OP_DIV} op_t;

   function automatic int iters(input int w, input logic div);
      return div ? w + 2 : w;
   endfunction

   function automatic int fq_width(input int mw);
      return mw + 4;
   endfunction

endpackage

// File: rtl/sigfmd_step.sv
// One radix-2 iteration: shift-add for multiply, trial subtract for divide.
module sigfmd_step
   import sigfmd_pkg::*;
#(
   parameter int W = 53
) (
   input  op_t          op,
   input  logic [W+1:0] acc,
   input  logic [W-1:0] opd,
   input  logic         lsb,
   output logic [W+1:0] nxt,
   output logic         qbit
);

   logic [W+1:0] ext;
   logic [W+1:0] sum;
   logic [W+1:0] diff;
   logic         ge;

   always_comb begin
      ext  = {2'b00, opd};
      sum  = acc + (lsb ? ext : '0);
      ge   = (acc >= ext);
      diff = ge ? (acc - ext) : acc;
      nxt  = '0;
      qbit = 1'b0;
      unique case (op)
         OP_MUL: begin
            nxt  = sum >> 1;
            qbit = sum[0];
         end
         OP_DIV: begin
            nxt  = diff << 1;
            qbit = ge;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sigfmd_seq.sv
// Sequential significand multiply/divide with valid/ready handshakes,
// single/double precision and synchronous flush.
module sigfmd_seq
   import sigfmd_pkg::*;
#(
   parameter int MW = 53,
   parameter int SW = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [MW-1:0] fa,
   input  logic [MW-1:0] fb,
   input  logic          fdiv,
   input  logic          db,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [MW+3:0] fq,
   output logic          dbz
);

   localparam int CW  = $clog2(MW + 3);
   localparam int FQW = fq_width(MW);

   state_t          st;
   op_t             op;
   logic            db_r;
   logic            load;
   logic [CW-1:0]   cnt;
   logic [MW-1:0]   a;
   logic [MW-1:0]   b;
   logic [MW+1:0]   acc;
   logic [MW:0]     lo;

   logic [MW+1:0]   nxt;
   logic            qbit;
   logic [2*MW-1:0] prod;
   logic [MW+1:0]   quo;
   logic [MW+2:0]   hi;
   logic            stk;
   logic [FQW-1:0]  res;

   assign in_ready = (st == IDLE) && !flush;

   sigfmd_step #(.W(MW)) u_step (
      .op   (op),
      .acc  (acc),
      .opd  (b),
      .lsb  (lo[0]),
      .nxt  (nxt),
      .qbit (qbit)
   );

   // Single-precision operands are zero-extended, so results sit at SW scale
   always_comb begin
      prod = {nxt[MW-1:0], qbit, lo[MW-1:1]};
      quo  = {lo, qbit};
      if (op == OP_MUL) begin
         stk = |prod[MW-4:0];
         hi  = db_r ? prod[2*MW-1:MW-3]
                    : {prod[MW+SW-1:MW-3], {(MW-SW){1'b0}}};
      end else begin
         stk = |nxt;
         hi  = db_r ? {1'b0, quo}
                    : {1'b0, quo[SW+1:0], {(MW-SW){1'b0}}};
      end
      res = {hi, stk};
      if (!db_r)
         res[MW-SW] = stk;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= IDLE;
         op        <= OP_MUL;
         db_r      <= 1'b0;
         load      <= 1'b0;
         cnt       <= '0;
         a         <= '0;
         b         <= '0;
         acc       <= '0;
         lo        <= '0;
         out_valid <= 1'b0;
         fq        <= '0;
         dbz       <= 1'b0;
      end else if (flush) begin
         st        <= IDLE;
         load      <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
      end else begin
         unique case (st)
            IDLE: if (in_valid) begin
               op   <= fdiv ? OP_DIV : OP_MUL;
               db_r <= db;
               a    <= db ? fa : {{(MW-SW){1'b0}}, fa[MW-1:MW-SW]};
               b    <= db ? fb : {{(MW-SW){1'b0}}, fb[MW-1:MW-SW]};
               cnt  <= CW'(iters(db ? MW : SW, fdiv));
               load <= 1'b1;
               st   <= BUSY;
            end
            BUSY: if (load) begin
               load <= 1'b0;
               acc  <= (op == OP_DIV) ? {2'b00, a} : '0;
               lo   <= (op == OP_DIV) ? '0 : {1'b0, a};
               if (op == OP_DIV && b == '0) begin
                  fq        <= '1;
                  dbz       <= 1'b1;
                  out_valid <= 1'b1;
                  st        <= DONE;
               end
            end else begin
               acc <= nxt;
               lo  <= (op == OP_MUL) ? {1'b0, qbit, lo[MW-1:1]}
                                     : {lo[MW-1:0], qbit};
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  fq        <= res;
                  dbz       <= 1'b0;
                  out_valid <= 1'b1;
                  st        <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               st        <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sigfmd_seq.sv
// Scoreboard bench for sigfmd_seq: arithmetic reference model, random traffic.
module tb_sigfmd_seq;

   localparam int MW = 53;
   localparam int SW = 24;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [MW-1:0] fa = '0;
   logic [MW-1:0] fb = '0;
   logic          fdiv = 1'b0;
   logic          db = 1'b0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [MW+3:0] fq;
   logic          dbz;

   typedef struct {
      logic [MW+3:0] fq;
      logic          dbz;
      int            lat;
      int            c0;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   hold = 1'b0;
   bit   shown = 1'b0;

   sigfmd_seq #(.MW(MW), .SW(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fa        (fa),
      .fb        (fb),
      .fdiv      (fdiv),
      .db        (db),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fq        (fq),
      .dbz       (dbz)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: exact integer product / quotient, then pick bits
   function automatic void model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                 input logic dv, input logic d,
                                 output logic [MW+3:0] r, output logic z,
                                 output int lat);
      logic [127:0] av, bv, p, num, qq, rm, t, mask;
      logic         sb;
      int           w;
      w  = d ? MW : SW;
      av = d ? 128'(a) : 128'(a) >> (MW - SW);
      bv = d ? 128'(b) : 128'(b) >> (MW - SW);
      z  = 1'b0;
      if (dv && bv == 0) begin
         r   = '1;
         z   = 1'b1;
         lat = 1;
         return;
      end
      lat = (dv ? w + 2 : w) + 1;
      if (!dv) begin
         p    = av * bv;
         mask = (128'd1 << (w - 3)) - 128'd1;
         sb   = (p & mask) != 0;
         t    = ((p >> (w - 3)) << 1) | {127'd0, sb};
      end else begin
         num = av << (w + 1);
         qq  = num / bv;
         rm  = num % bv;
         sb  = (rm != 0);
         t   = (qq << 1) | {127'd0, sb};
      end
      if (d)
         r = t[MW+3:0];
      else
         r = (MW+4)'(t << (MW - SW)) | {{(MW+3){1'b0}}, t[0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic txn(input logic [MW-1:0] a, input logic [MW-1:0] b,
                      input logic dv, input logic d, input bit push);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready stuck at %b", in_ready);
         return;
      end
      fa       = a;
      fb       = b;
      fdiv     = dv;
      db       = d;
      in_valid = 1'b1;
      if (push) begin
         model(a, b, dv, d, e.fq, e.dbz, e.lat);
         e.c0 = cyc;
         q.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
         q.delete();
      end
   endtask

   // Monitor: compares every presented result against the queue head
   always @(negedge clk) begin
      if (rst) begin
         shown = 1'b0;
      end else begin
         out_ready = hold ? 1'b0 : 1'($urandom_range(0, 1));
         if (out_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_out: out_valid=1 fq=%h, expected no result", fq);
            end else begin
               check("fq", 64'(fq), 64'(q[0].fq));
               check("dbz", 64'(dbz), 64'(q[0].dbz));
               check("in_ready_busy", 64'(in_ready), 64'd0);
               if (!shown) begin
                  check("latency", 64'(cyc - q[0].c0 - 1), 64'(q[0].lat));
                  shown = 1'b1;
               end
               if (out_ready) begin
                  void'(q.pop_front());
                  shown = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      logic [MW-1:0] ra, rb;
      int            n;

      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_fq", 64'(fq), 64'd0);
      check("rst_dbz", 64'(dbz), 64'd0);
      rst = 1'b0;

      txn(53'd1 << 52, 53'd1 << 52, 1'b0, 1'b1, 1'b1);
      txn(53'd3 << 51, 53'd3 << 51, 1'b0, 1'b1, 1'b1);
      txn(53'd1 << 52, 53'd3 << 51, 1'b1, 1'b1, 1'b1);
      txn(53'd1 << 52, 53'd0, 1'b1, 1'b1, 1'b1);
      drain();

      hold = 1'b1;
      txn(53'd1 << 52, 53'd1 << 52, 1'b0, 1'b0, 1'b1);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      hold = 1'b0;
      drain();

      for (int i = 0; i < 40; i++) begin
         ra = {1'b1, 52'($urandom), 20'($urandom)} >> 20;
         ra[MW-1] = 1'b1;
         rb = {1'b1, 52'($urandom), 20'($urandom)} >> 20;
         rb[MW-1] = 1'b1;
         if ($urandom_range(0, 7) == 0)
            rb = '0;
         txn(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      end
      drain();

      txn(53'd1 << 52, 53'd3 << 51, 1'b1, 1'b1, 1'b0);
      repeat (19) @(negedge clk);
      flush = 1'b1;
      #1 check("flush_gates_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      #1 check("flush_idle_ready", 64'(in_ready), 64'd1);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      repeat (70) @(negedge clk);

      in_valid = 1'b1;
      flush    = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      #1 check("flush_blocks_accept", 64'(in_ready), 64'd1);
      txn(53'd3 << 51, 53'd1 << 52, 1'b1, 1'b1, 1'b1);
      drain();

      txn(53'd3 << 51, 53'd3 << 51, 1'b0, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_out_valid", 64'(out_valid), 64'd0);
      check("rst_mid_in_ready", 64'(in_ready), 64'd1);
      check("rst_mid_fq", 64'(fq), 64'd0);
      check("rst_mid_dbz", 64'(dbz), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      txn(53'd3 << 51, 53'd3 << 51, 1'b1, 1'b0, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
